// File: rtl/uart_recv.sv
// Purpose  : 8N1 UART receiver, LSB first, mid-bit sampling after a 2-FF synchronizer.
// Latency  : uart_en/frame_err rise 9*BPS_CNT + BPS_CNT/2 + 3 clocks after the start-bit falling edge.
// Backpress: none; uart_en/frame_err are single-cycle pulses, consumer must capture uart_data on uart_en.
// Ports    : sys_clk/sys_rst (async active-low), uart_rxd serial in;
//            uart_data last good byte, uart_en good-byte pulse, frame_err bad-stop pulse, rx_busy not idle.
module uart_recv #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200,
    parameter int BPS_CNT  = CLK_FREQ / UART_BPS
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_en,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = ($clog2(BPS_CNT) > 16) ? $clog2(BPS_CNT) : 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_CNT / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic             rx_p_q, rx_p_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_reg_q, shift_reg_d;
    logic [7:0]       uart_data_q, uart_data_d;
    logic             uart_en_q, uart_en_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q, rx_busy_d;

    logic sample_pt;
    logic bit_end;
    logic start_edge;

    assign sample_pt  = (clk_cnt_q == CNT_MID);
    assign bit_end    = (clk_cnt_q == CNT_LAST);
    // Requiring a high-to-low transition keeps a line stuck low from re-triggering.
    assign start_edge = rx_p_q & ~rx_s_q;

    // State register. Synchronizer flops reset high so release never fakes a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_p_q      <= 1'b1;
            clk_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            shift_reg_q <= 8'h00;
            uart_data_q <= 8'h00;
            uart_en_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            rx_p_q      <= rx_p_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_reg_q <= shift_reg_d;
            uart_data_q <= uart_data_d;
            uart_en_q   <= uart_en_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_edge) state_d = START;
            START: begin
                if (sample_pt && rx_s_q) state_d = IDLE;   // start bit gone high: glitch
                else if (bit_end)        state_d = DATA;
            end
            DATA:  if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
            // Leave at mid stop bit so a start bit directly after it is caught.
            STOP:  if (sample_pt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and outputs.
    always_comb begin
        rx_meta_d   = uart_rxd;
        rx_s_d      = rx_meta_q;
        rx_p_d      = rx_s_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_reg_d = shift_reg_q;
        uart_data_d = uart_data_q;
        uart_en_d   = 1'b0;
        frame_err_d = 1'b0;
        rx_busy_d   = (state_d != IDLE);

        // Counter is held at zero in IDLE, so it starts at zero on entry to START.
        if ((state_q == IDLE) || (state_d == IDLE)) begin
            clk_cnt_d = '0;
        end else if (bit_end) begin
            clk_cnt_d = '0;
        end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end

        if (state_q == START) begin
            bit_idx_d = 3'd0;
        end else if ((state_q == DATA) && bit_end) begin
            bit_idx_d = bit_idx_q + 3'd1;
        end

        if ((state_q == DATA) && sample_pt) begin
            shift_reg_d[bit_idx_q] = rx_s_q;
        end

        if ((state_q == STOP) && sample_pt) begin
            uart_en_d   = rx_s_q;
            frame_err_d = ~rx_s_q;
            if (rx_s_q) uart_data_d = shift_reg_q;
        end
    end

    assign uart_data = uart_data_q;
    assign uart_en   = uart_en_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// Purpose  : self-checking bench for uart_recv at default and reduced (10 clk/bit) baud settings.
// Latency  : events are paired with the frames that caused them and their delay range-checked.
// Backpress: n/a; the bench drives the serial lines and records every output pulse.
module tb_uart_recv;

    localparam int BPC   = 434;
    localparam int BPC_S = 10;

    logic       sys_clk    = 1'b0;
    logic       sys_rst    = 1'b0;
    logic       uart_rxd   = 1'b1;
    logic       uart_rxd_s = 1'b1;
    logic [7:0] uart_data, uart_data_s;
    logic       uart_en, uart_en_s;
    logic       frame_err, frame_err_s;
    logic       rx_busy, rx_busy_s;

    uart_recv dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .uart_data(uart_data),
        .uart_en  (uart_en),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    uart_recv #(.CLK_FREQ(1000000), .UART_BPS(100000)) dut_s (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd_s),
        .uart_data(uart_data_s),
        .uart_en  (uart_en_s),
        .frame_err(frame_err_s),
        .rx_busy  (rx_busy_s)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // One received (or expected) event: good byte or framing error, with its cycle stamp.
    typedef struct {
        bit         err;
        logic [7:0] dat;
        int         cyc;
    } ev_t;

    ev_t obs_q[$], obs_s_q[$], exp_q[$], exp_s_q[$];

    // Reference view of what uart_data should hold: last byte sent with a high stop bit.
    logic [7:0] model_dat   = 8'h00;
    logic [7:0] model_dat_s = 8'h00;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Record every output pulse, one entry per high cycle.
    always @(negedge sys_clk) begin : mon
        ev_t e;
        if (uart_en || frame_err) begin
            chk("en_err_excl", {31'b0, uart_en & frame_err}, 32'd0);
            e.err = frame_err; e.dat = uart_data; e.cyc = cyc;
            obs_q.push_back(e);
        end
        if (uart_en_s || frame_err_s) begin
            chk("en_err_excl_s", {31'b0, uart_en_s & frame_err_s}, 32'd0);
            e.err = frame_err_s; e.dat = uart_data_s; e.cyc = cyc;
            obs_s_q.push_back(e);
        end
    end

    // Drive a line level, then let n clocks pass; always leaves time at posedge+1.
    task automatic line(input bit sel, input logic v, input int n);
        if (sel) uart_rxd_s = v;
        else     uart_rxd   = v;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stopb);
        int  bpc;
        ev_t e;
        bpc   = sel ? BPC_S : BPC;
        e.err = ~stopb;
        e.cyc = cyc;
        if (stopb) begin
            if (sel) model_dat_s = b;
            else     model_dat   = b;
        end
        e.dat = sel ? model_dat_s : model_dat;
        if (sel) exp_s_q.push_back(e);
        else     exp_q.push_back(e);
        line(sel, 1'b0, bpc);
        chk(sel ? "busy_in_frame_s" : "busy_in_frame", {31'b0, sel ? rx_busy_s : rx_busy}, 32'd1);
        for (int i = 0; i < 8; i++) line(sel, b[i], bpc);
        line(sel, stopb, bpc);
    endtask

    // Pair observed events with expected ones in order, then check held data.
    task automatic score(input bit sel);
        ev_t oq[$], xq[$], o, x;
        int  lo, hi, lat, clamped;
        lo = sel ? 95 : 4123;
        hi = sel ? 102 : 4130;
        if (sel) begin
            oq = obs_s_q; xq = exp_s_q; obs_s_q = {}; exp_s_q = {};
        end else begin
            oq = obs_q; xq = exp_q; obs_q = {}; exp_q = {};
        end
        chk("ev_count", oq.size(), xq.size());
        while (oq.size() > 0 && xq.size() > 0) begin
            o = oq.pop_front();
            x = xq.pop_front();
            chk("ev_kind_err", {31'b0, o.err}, {31'b0, x.err});
            chk("ev_data", {24'b0, o.dat}, {24'b0, x.dat});
            lat     = o.cyc - x.cyc;
            clamped = (lat < lo) ? lo : ((lat > hi) ? hi : lat);
            chk("ev_latency", lat, clamped);
        end
        chk(sel ? "held_data_s" : "held_data", {24'b0, sel ? uart_data_s : uart_data},
            {24'b0, sel ? model_dat_s : model_dat});
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int f, rel, k, gap;
        logic [7:0] b;
        logic       s;

        // Reset values.
        repeat (5) @(posedge sys_clk);
        #1;
        chk("rst_data", {24'b0, uart_data}, 32'h0);
        chk("rst_en", {31'b0, uart_en}, 32'd0);
        chk("rst_err", {31'b0, frame_err}, 32'd0);
        chk("rst_busy", {31'b0, rx_busy}, 32'd0);
        chk("rst_data_s", {24'b0, uart_data_s}, 32'h0);
        chk("rst_busy_s", {31'b0, rx_busy_s}, 32'd0);
        sys_rst = 1'b1;
        line(0, 1'b1, 20);

        // Single byte.
        send_frame(0, 8'h55, 1'b1);
        line(0, 1'b1, 5);
        chk("busy_after_55", {31'b0, rx_busy}, 32'd0);
        score(0);

        // Back-to-back, no idle gap.
        send_frame(0, 8'hA3, 1'b1);
        send_frame(0, 8'h0F, 1'b1);
        line(0, 1'b1, 5);
        score(0);

        // Glitch: 100 clocks low.
        f = cyc;
        line(0, 1'b0, 10);
        chk("glitch_busy_rise", {31'b0, rx_busy}, 32'd1);
        line(0, 1'b0, 90);
        line(0, 1'b1, 0);
        k = 0;
        while (rx_busy && k < 1000) begin
            @(posedge sys_clk);
            #1;
            k++;
        end
        rel = cyc - f;
        chk("glitch_busy_fall", rel, (rel < 212) ? 212 : ((rel > 226) ? 226 : rel));
        line(0, 1'b1, BPC);
        score(0);

        // Framing error, then line stuck low.
        send_frame(0, 8'h12, 1'b1);
        send_frame(0, 8'h81, 1'b0);
        line(0, 1'b0, 1000);
        chk("stuck_low_idle_a", {31'b0, rx_busy}, 32'd0);
        line(0, 1'b0, 1000);
        chk("stuck_low_idle_b", {31'b0, rx_busy}, 32'd0);
        line(0, 1'b1, BPC);
        score(0);
        send_frame(0, 8'h5A, 1'b1);
        line(0, 1'b1, 5);
        score(0);

        // Reset during data bit 4 of 0xFF.
        line(0, 1'b0, BPC);
        line(0, 1'b1, 4 * BPC + 200);
        sys_rst = 1'b0;
        line(0, 1'b1, 3);
        chk("midrst_data", {24'b0, uart_data}, 32'h0);
        chk("midrst_en", {31'b0, uart_en}, 32'd0);
        chk("midrst_err", {31'b0, frame_err}, 32'd0);
        chk("midrst_busy", {31'b0, rx_busy}, 32'd0);
        model_dat   = 8'h00;
        model_dat_s = 8'h00;
        sys_rst = 1'b1;
        line(0, 1'b1, BPC);
        score(0);
        send_frame(0, 8'h3C, 1'b1);
        line(0, 1'b1, 5);
        score(0);

        // A few random bytes at the default rate with random idle gaps.
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(255, 0));
            send_frame(0, b, 1'b1);
            score(0);
            line(0, 1'b1, $urandom_range(BPC, 0));
        end

        // Reduced-rate instance: directed 0xC6, then random frames with occasional bad stop bits.
        send_frame(1, 8'hC6, 1'b1);
        score(1);
        line(1, 1'b1, 3);
        for (int i = 0; i < 60; i++) begin
            b = 8'($urandom_range(255, 0));
            s = ($urandom_range(4, 0) != 0);
            send_frame(1, b, s);
            score(1);
            // After a low stop bit the line must go high again before a new frame counts.
            gap = s ? $urandom_range(3, 0) : $urandom_range(3, 1);
            if (gap > 0) line(1, 1'b1, gap * BPC_S + $urandom_range(BPC_S - 1, 0));
        end
        line(1, 1'b1, 3 * BPC_S);
        chk("busy_end_s", {31'b0, rx_busy_s}, 32'd0);
        score(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200: baud rate.
REQ-003 Parameter BPS_CNT, default CLK_FREQ/UART_BPS (integer division, 434): clocks per bit.
REQ-004 sys_clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-005 sys_rst  input  1  reset, asynchronous, active-low.
REQ-006 uart_rxd  input  1  asynchronous serial line, 8N1, LSB first; idles high.
REQ-007 uart_data  output  8  last correctly framed byte.
REQ-008 uart_en  output  1  one-cycle pulse: new byte valid on uart_data. Consumers rising-edge detect it.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 rx_busy  output  1  high while the state machine is not in IDLE.

Function
REQ-011 uart_rxd SHALL pass through a 2-FF synchronizer, giving rx_s.
- A third register rx_p SHALL hold the previous rx_s.
- A start edge is rx_p==1 and rx_s==0.
REQ-012 States SHALL be IDLE, START, DATA and STOP.
- rx_busy = (state != IDLE), registered with the state.
REQ-013 clk_cnt SHALL count 0..BPS_CNT-1 and wrap to 0.
- It counts every cycle outside IDLE.
- It SHALL be 0 on entry to START.
- The sample point is clk_cnt == BPS_CNT/2 (integer, 217).
REQ-014 IDLE -> START on a start edge only.
- A line that is low but has no preceding high SHALL NOT start a frame.
REQ-015 START behaviour:
- If rx_s==1 at the sample point: false start; return to IDLE next cycle; no uart_en, no frame_err.
- Otherwise, at clk_cnt==BPS_CNT-1: go to DATA with bit_idx=0.
REQ-016 DATA behaviour:
- At each sample point, rx_s SHALL be written into shift_reg[bit_idx] (LSB first).
- At clk_cnt==BPS_CNT-1: bit_idx increments, 3-bit. When bit_idx==7, go to STOP instead.
REQ-017 STOP, at the sample point:
- rx_s==1: uart_data<=shift_reg and uart_en=1 for exactly the next cycle.
- rx_s==0: frame_err=1 for exactly the next cycle; uart_data unchanged.
- In both cases go to IDLE immediately, without waiting for the end of the stop bit, so back-to-back frames are accepted.
REQ-018 uart_data SHALL hold its value between good frames and never change on an error or false start.
REQ-019 uart_en and frame_err SHALL never assert in the same cycle.
- Neither SHALL be high for more than 1 cycle per frame.
REQ-020 Latency: uart_en SHALL rise 4123..4130 clocks after uart_rxd falls.
- This is 9*BPS_CNT + BPS_CNT/2 plus synchronizer and output-register delay.
REQ-021 After an error frame with the line stuck low, reception resumes only after the line returns high, followed by a new falling edge.
REQ-022 Widths: clk_cnt SHALL be wide enough for BPS_CNT-1 (min 16 bits). No arithmetic overflow is permitted.

Reset
REQ-023 While sys_rst==0, the following SHALL hold:
- state=IDLE, clk_cnt=0, bit_idx=0, shift_reg=0.
- uart_data=8'h00, uart_en=0, frame_err=0, rx_busy=0.
- Synchronizer and rx_p registers = 1, so no false edge occurs after reset release.
REQ-024 Reset mid-frame SHALL abort the frame with no uart_en or frame_err.
- The first full frame after release SHALL be received correctly.

Verification
REQ-025 Single byte: send 0x55 at 115200 (434 clk/bit).
- uart_data=0x55; uart_en high exactly 1 cycle, within 4123..4130 cycles of the falling edge.
- rx_busy high throughout, low after.
REQ-026 Back-to-back: 0xA3 then 0x0F, no idle gap after the stop bit.
- Two uart_en pulses: uart_data 0xA3, then 0x0F.
- frame_err never asserts.
REQ-027 Glitch: rxd low for 100 clocks, then high.
- rx_busy rises, then falls about 217 clocks after the edge.
- No uart_en, no frame_err; uart_data unchanged.
REQ-028 Framing error: receive 0x12 correctly, then send 0x81 with stop bit=0.
- frame_err pulses 1 cycle; uart_data stays 0x12; no uart_en.
- With the line held low after the error, no new frame starts until the line returns high.
REQ-029 Reset mid-frame: assert sys_rst during data bit 4 of 0xFF.
- All outputs go to reset values; no pulse.
- After release, send 0x3C: uart_data=0x3C with one uart_en pulse.
REQ-030 Parameter override: CLK_FREQ=1000000, UART_BPS=100000 (BPS_CNT=10).
- Byte 0xC6 is received correctly.
- uart_en rises within 95..102 cycles of the falling edge.
